// File: rtl/mult_accumulator.sv
// mult_accumulator: sums N_TERMS unsigned products into a saturating
// SUM_WIDTH-bit result, presented with a valid/ready handshake.
// The result is held until downstream consumes it. A sticky ovf flag
// records any saturation that occurred within the batch.
module mult_accumulator #(
    parameter int N_TERMS   = 4,
    parameter int P_WIDTH   = 6,
    parameter int SUM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [P_WIDTH-1:0]   in_p,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SUM_WIDTH-1:0] sum,
    output logic                 ovf
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SUM_WIDTH-1:0]   acc;
    logic [CNT_W-1:0]       count;
    logic                   ovf_q;

    logic                   accept;
    logic [SUM_WIDTH:0]     p_ext;
    logic [SUM_WIDTH:0]     add_full;
    logic                   add_ovf;
    logic [SUM_WIDTH-1:0]   add_sat;

    // Accept a product whenever the block is not holding a result.
    always_comb begin
        accept = in_valid && (state != DONE);
    end

    // One-bit-wider add of the zero-extended product, clamped to all-ones on carry.
    always_comb begin
        p_ext                = '0;
        p_ext[P_WIDTH-1:0]   = in_p;
        add_full             = {1'b0, acc} + p_ext;
        add_ovf              = add_full[SUM_WIDTH];
        add_sat              = add_ovf ? '1 : add_full[SUM_WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start batch, finish on last accept, release on out_ready.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = ACC;
            ACC:  if (accept && (count == LAST)) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Accumulator, term counter and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            ovf_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= p_ext[SUM_WIDTH-1:0];
                        count <= CNT_W'(1);
                        ovf_q <= 1'b0;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc   <= add_sat;
                        count <= count + CNT_W'(1);
                        ovf_q <= ovf_q | add_ovf;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc   <= '0;
                        count <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                default: begin
                    acc   <= '0;
                    count <= '0;
                    ovf_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs decoded from state only; result forced to zero unless valid.
    always_comb begin
        in_ready  = (state != DONE);
        out_valid = (state == DONE);
        sum       = (state == DONE) ? acc : '0;
        ovf       = (state == DONE) ? ovf_q : 1'b0;
    end

endmodule
